// File: rtl/fp_pkg.sv
// Shared floating-point constants and the normalize/round -> pack pipeline payload.
package fp_pkg;

  localparam int FP_EXP_W  = 10;
  localparam int FP_Q_W    = 26;
  localparam int FP_MANT_W = 24;

  localparam int          FP_EXP_BIAS = 127;
  localparam int          FP_EXP_MAX  = 255;
  localparam logic [7:0]  FP_INF_EXP  = 8'hFF;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;

  // mant_r carries the hidden bit in its MSB; the exponent is already carry-adjusted.
  typedef struct packed {
    logic                       sign;
    logic signed [FP_EXP_W-1:0] exp;
    logic [FP_MANT_W-1:0]       mant_r;
    logic                       special;
    logic [31:0]                special_res;
    logic                       inexact;
  } fp_s1_t;

endpackage

// File: rtl/fp_rne_rounder.sv
// Combinational round-to-nearest-even on a 24-bit significand with guard/sticky.
module fp_rne_rounder
  import fp_pkg::*;
(
  input  logic [FP_MANT_W-1:0] mant,
  input  logic                 guard,
  input  logic                 sticky,
  output logic [FP_MANT_W-1:0] mant_r,
  output logic                 carry,
  output logic                 inexact
);

  logic                 inc;
  logic [FP_MANT_W:0]   sum;

  assign inc     = guard & (sticky | mant[0]);
  assign sum     = {1'b0, mant} + {{FP_MANT_W{1'b0}}, inc};
  assign carry   = sum[FP_MANT_W];
  // A carry out leaves 1.000..0 * 2, so the renormalized significand drops the zero LSB.
  assign mant_r  = carry ? sum[FP_MANT_W:1] : sum[FP_MANT_W-1:0];
  assign inexact = guard | sticky;

endmodule

// File: rtl/fp_div_round_pack.sv
// Divider post-stage: S1 normalize/round, S2 classify/pack into IEEE-754 single.
// Optional out_inexact flag is built when FP_DIV_EXC_FLAGS_EN is defined.
module fp_div_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int Q_W   = FP_Q_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [Q_W-1:0]          in_q,
  input  logic                    in_sticky,
  input  logic                    in_special,
  input  logic [31:0]             in_special_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic                    out_overflow,
  output logic                    out_underflow
`ifdef FP_DIV_EXC_FLAGS_EN
  ,output logic                   out_inexact
`endif
);

  localparam logic signed [EXP_W-1:0] EXP_MAX_S  = EXP_W'(FP_EXP_MAX);
  localparam logic signed [EXP_W-1:0] EXP_ZERO_S = '0;

  fp_s1_t                  s1_d, s1_q;
  logic                    s1_valid, s2_move;
  logic [FP_MANT_W-1:0]    mant_n, rnd_mant;
  logic                    guard_n, sticky_n, rnd_carry, rnd_inexact;
  logic signed [EXP_W-1:0] exp_n;
  logic [31:0]             res_d;
  logic                    ovf_d, unf_d;
  logic                    unused_bits;

  // Handshake: a beat moves across a boundary on a rising edge where valid && ready.
  // Each stage loads when empty or when its content leaves this cycle; in_ready is
  // combinational from out_ready, and outputs hold steady while out_valid && !out_ready.
  assign s2_move  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_move;

  always_comb begin
    mant_n   = '0;
    guard_n  = 1'b0;
    sticky_n = in_sticky;
    exp_n    = in_exp;
    if (in_q[Q_W-1]) begin
      mant_n   = in_q[Q_W-1:Q_W-24];
      guard_n  = in_q[Q_W-25];
      sticky_n = in_sticky | in_q[Q_W-26];
    end else begin
      mant_n   = in_q[Q_W-2:Q_W-25];
      guard_n  = in_q[Q_W-26];
      exp_n    = in_exp - EXP_W'(1);
    end
  end

  fp_rne_rounder u_rounder (
    .mant    (mant_n),
    .guard   (guard_n),
    .sticky  (sticky_n),
    .mant_r  (rnd_mant),
    .carry   (rnd_carry),
    .inexact (rnd_inexact)
  );

  always_comb begin
    s1_d             = '0;
    s1_d.sign        = in_sign;
    s1_d.exp         = exp_n + EXP_W'(rnd_carry);
    s1_d.mant_r      = rnd_mant;
    s1_d.special     = in_special;
    s1_d.special_res = in_special_res;
`ifdef FP_DIV_EXC_FLAGS_EN
    s1_d.inexact     = rnd_inexact;
`else
    s1_d.inexact     = 1'b0;
`endif
  end

`ifdef FP_DIV_EXC_FLAGS_EN
  assign unused_bits = s1_q.mant_r[FP_MANT_W-1];
`else
  assign unused_bits = ^{s1_q.mant_r[FP_MANT_W-1], s1_q.inexact, rnd_inexact};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Saturate to Inf on exponent overflow; flush to signed zero (no subnormals).
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s1_q.special) begin
      res_d = s1_q.special_res;
    end else if (s1_q.exp >= EXP_MAX_S) begin
      res_d = {s1_q.sign, FP_INF_EXP, 23'h0};
      ovf_d = 1'b1;
    end else if (s1_q.exp <= EXP_ZERO_S) begin
      res_d = {s1_q.sign, 31'h0};
      unf_d = 1'b1;
    end else begin
      res_d = {s1_q.sign, s1_q.exp[7:0], s1_q.mant_r[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
`ifdef FP_DIV_EXC_FLAGS_EN
      out_inexact   <= 1'b0;
`endif
    end else if (s2_move) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= res_d;
        out_overflow  <= ovf_d;
        out_underflow <= unf_d;
`ifdef FP_DIV_EXC_FLAGS_EN
        out_inexact   <= !s1_q.special && (s1_q.inexact || ovf_d || unf_d);
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_div_round_pack.sv
// Self-checking bench for fp_div_round_pack: directed vectors, backpressure, bypass,
// mid-stream reset and randomized traffic against a value-level reference model.
module tb_fp_div_round_pack;
  import fp_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_sign, in_sticky, in_special;
  logic signed [9:0] in_exp;
  logic [25:0]       in_q;
  logic [31:0]       in_special_res;
  logic              out_valid, out_ready, out_overflow, out_underflow;
  logic [31:0]       out_result;
`ifdef FP_DIV_EXC_FLAGS_EN
  logic              out_inexact;
`endif

  int checks = 0, errors = 0;
  int sb_checks = 0, sb_errors = 0;
  int n_in = 0, n_out = 0;
  bit rand_ready = 1'b0;
  logic [34:0] exp_q[$];
  logic [34:0] sb_e;

  always #5 clk = ~clk;

  fp_div_round_pack dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_q           (in_q),
    .in_sticky      (in_sticky),
    .in_special     (in_special),
    .in_special_res (in_special_res),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_overflow   (out_overflow),
    .out_underflow  (out_underflow)
`ifdef FP_DIV_EXC_FLAGS_EN
    ,.out_inexact   (out_inexact)
`endif
  );

  // Reference: value q/2^25 * 2^(exp-127), rounded to 24 significant bits, nearest-even.
  // Returns {result, overflow, underflow, inexact}.
  function automatic logic [34:0] model(input logic sign, input logic signed [9:0] ex,
                                        input logic [25:0] q, input logic sticky,
                                        input logic special, input logic [31:0] res);
    longint sig, keep, rem;
    int e;
    bit up, inx;
    logic [7:0] ef;
    logic [22:0] ff;
    if (special) return {res, 3'b000};
    sig = longint'(q);
    e   = int'(ex);
    if (sig < (longint'(1) << 25)) begin
      sig = sig * 2;
      e   = e - 1;
    end
    keep = sig / 4;
    rem  = sig % 4;
    up   = (rem > 2) || (rem == 2 && (sticky || (keep % 2) == 1));
    inx  = (rem != 0) || sticky;
    if (up) keep = keep + 1;
    if (keep == (longint'(1) << 24)) begin
      keep = keep / 2;
      e    = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'h0, 3'b101};
    if (e <= 0)   return {sign, 31'h0, 3'b011};
    ef = 8'(e);
    ff = 23'(keep);
    return {sign, ef, ff, 2'b00, inx};
  endfunction

  // Scoreboard: transfers are decided at the next rising edge; sample on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_sign, in_exp, in_q, in_sticky, in_special, in_special_res));
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        sb_checks++;
        if (exp_q.size() == 0) begin
          sb_errors++;
          $display("FAIL sb_unexpected: result %h arrived with no expected beat", out_result);
        end else begin
          sb_e = exp_q.pop_front();
          if ({out_result, out_overflow, out_underflow} !== sb_e[34:1]) begin
            sb_errors++;
            $display("FAIL sb_result: got %h ovf=%b unf=%b, expected %h ovf=%b unf=%b",
                     out_result, out_overflow, out_underflow, sb_e[34:3], sb_e[2], sb_e[1]);
          end
`ifdef FP_DIV_EXC_FLAGS_EN
          sb_checks++;
          if (out_inexact !== sb_e[0]) begin
            sb_errors++;
            $display("FAIL sb_inexact: got %b, expected %b (result %h)", out_inexact, sb_e[0], out_result);
          end
`endif
        end
      end
    end
  end

  task automatic send(input logic s, input logic signed [9:0] e, input logic [25:0] q,
                      input logic st, input logic sp, input logic [31:0] r);
    int  waited = 0;
    bit  ok;
    in_sign = s; in_exp = e; in_q = q; in_sticky = st; in_special = sp; in_special_res = r;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      waited++;
    end while (!ok && waited < 100);
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
    end
  endtask

  task automatic drain();
    int waited = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sign = 1'b0; in_exp = '0;
    in_q = '0; in_sticky = 1'b0; in_special = 1'b0; in_special_res = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_result, out_overflow, out_underflow, in_ready} !== {1'b0, 32'h0, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: valid=%b result=%h ovf=%b unf=%b in_ready=%b, expected 0 0 0 0 1",
               out_valid, out_result, out_overflow, out_underflow, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_directed();
    logic        ds[12]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int          de[12]  = '{127, 127, 127, 127, 255, 0, 1, 254, 254, 1, 127, 127};
    logic [25:0] dq[12]  = '{26'h2000000, 26'h1000000, 26'h1000000, 26'h3FFFFFE, 26'h2000000,
                             26'h2000000, 26'h1000000, 26'h2000000, 26'h3FFFFFE, 26'h2000000,
                             26'h2000002, 26'h2000002};
    logic        dst[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [31:0] dr[12]  = '{32'h3F800000, 32'h3F000000, 32'hBF000000, 32'h40000000, 32'h7F800000,
                             32'h80000000, 32'h00000000, 32'h7F000000, 32'h7F800000, 32'h00800000,
                             32'h3F800000, 32'h3F800001};
    logic [1:0]  df[12]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00,
                             2'b00, 2'b00};
`ifdef FP_DIV_EXC_FLAGS_EN
    logic        dx[12]  = '{0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 1};
`endif
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(ds[i], 10'(de[i]), dq[i], dst[i], 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early[%0d]: out_valid=%b one cycle after accept, expected 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, out_result, out_overflow, out_underflow} !== {1'b1, dr[i], df[i]}) begin
        errors++;
        $display("FAIL directed[%0d]: valid=%b result=%h ovf=%b unf=%b, expected 1 %h %b %b",
                 i, out_valid, out_result, out_overflow, out_underflow, dr[i], df[i][1], df[i][0]);
      end
`ifdef FP_DIV_EXC_FLAGS_EN
      checks++;
      if (out_inexact !== dx[i]) begin
        errors++;
        $display("FAIL directed_inexact[%0d]: got %b, expected %b", i, out_inexact, dx[i]);
      end
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] first;
    int base;
    rand_ready = 1'b0;
    out_ready  = 1'b0;
    base  = n_out;
    first = model(1'b0, 10'sd127, 26'h2000000, 1'b0, 1'b0, 32'h0);
    send(1'b0, 10'sd127, 26'h2000000, 1'b0, 1'b0, 32'h0);
    send(1'b0, 10'sd128, 26'h2000000, 1'b0, 1'b0, 32'h0);
    in_sign = 1'b0; in_exp = 10'sd128; in_q = 26'h3000000; in_sticky = 1'b0; in_special = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, first[34:3]}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: in_ready=%b valid=%b result=%h, expected 0 1 %h",
                 i, in_ready, out_valid, out_result, first[34:3]);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1'b0, 10'sd128, 26'h3000000, 1'b0, 1'b0, 32'h0);
    drain();
    checks++;
    if (n_out - base != 3) begin
      errors++;
      $display("FAIL backpressure_count: %0d results emerged, expected 3", n_out - base);
    end
  endtask

  task automatic test_special();
    int base = n_out;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    send(1'b0, 10'sd130, 26'h2400000, 1'b1, 1'b0, 32'h0);
    send(1'b1, 10'sd300, 26'h2000000, 1'b0, 1'b1, FP_QNAN);
    send(1'b1, 10'sd100, 26'h17FFFFF, 1'b0, 1'b0, 32'h0);
    send(1'b0, -10'sd50, 26'h1000000, 1'b1, 1'b1, 32'hFF800000);
    send(1'b0, 10'sd127, 26'h3FFFFFF, 1'b1, 1'b0, 32'h0);
    drain();
    checks++;
    if (n_out - base != 5) begin
      errors++;
      $display("FAIL special_count: %0d results emerged, expected 5", n_out - base);
    end
  endtask

  task automatic test_reset_mid();
    rand_ready = 1'b0;
    out_ready  = 1'b0;
    send(1'b0, 10'sd127, 26'h2000000, 1'b0, 1'b0, 32'h0);
    send(1'b1, 10'sd140, 26'h3000000, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_result} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid: valid=%b result=%h, expected 0 00000000", out_valid, out_result);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale[%0d]: out_valid=%b after release, expected 0", i, out_valid);
      end
    end
    @(posedge clk);
    #1;
    send(1'b0, 10'sd129, 26'h2800000, 1'b0, 1'b0, 32'h0);
    drain();
  endtask

  task automatic test_random();
    logic [25:0] q;
    int ev;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) q = {1'b1, 25'($urandom)};
      else                           q = {2'b01, 24'($urandom)};
      ev = int'($urandom_range(0, 506)) - 126;
      send(1'($urandom), 10'(ev), q, 1'($urandom), ($urandom_range(0, 9) == 0), $urandom);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_special();
    test_random();
    test_reset_mid();
    @(negedge clk);
    checks++;
    if (n_out != n_in - 2) begin
      errors++;
      $display("FAIL totals: %0d results for %0d accepted beats (2 discarded by reset)", n_out, n_in);
    end
    checks += sb_checks;
    errors += sb_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
